// File: rtl/pe_requant_lanes_if.sv
// pe_requant_lanes_if: stream bus for the requant lanes block.
// Input beats of lane MACC results in; assembled output vectors out.
//   i_data/i_valid/i_ready : MACC beat handshake (slave receives)
//   o_data/o_valid/o_ready : output vector handshake (slave sends)
interface pe_requant_lanes_if #(
  parameter int NUM_LANES   = 2,
  parameter int OUT_CHANNEL = 8,
  parameter int MACC_WIDTH  = 21,
  parameter int OW          = 16
);
  logic [MACC_WIDTH*NUM_LANES-1:0] i_data;
  logic                            i_valid;
  logic                            i_ready;
  logic [OW*OUT_CHANNEL-1:0]       o_data;
  logic                            o_valid;
  logic                            o_ready;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_valid
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_valid
  );
endinterface

// File: rtl/pe_requant_lanes.sv
// pe_requant_lanes: per-lane MACC requantisation with vector assembly.
// Ports: clk, rst (async high), bus (slave modport of the stream
//   interface), weight_wr_data/addr/en (bias, coeff, layer_scale regs).
// Relu mode: 2 pipeline stages, 8-bit channels clamped to [0,127].
// Dequant mode: 3 pipeline stages, 16-bit channels.
module pe_requant_lanes #(
  parameter int          NUM_LANES      = 2,
  parameter int          OUT_CHANNEL    = 8,
  parameter int          MACC_WIDTH     = 21,
  parameter              OUTPUT_MODE    = "dequant",
  parameter int unsigned BIAS_BASE_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_requant_lanes_if.slave    bus,
  input  logic [15:0]          weight_wr_data,
  input  logic [31:0]          weight_wr_addr,
  input  logic                 weight_wr_en
);
  localparam bit DQ = (OUTPUT_MODE == "dequant");
  localparam int OW = DQ ? 16 : 8;
  localparam int NL = NUM_LANES;
  localparam int OC = OUT_CHANNEL;
  localparam int MW = MACC_WIDTH;
  localparam int G  = (OC + NL - 1) / NL;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int PW = MW + 16;
  localparam int SW = ((PW > 24) ? PW : 24) + 1;
  localparam logic [31:0] COEFF_ADDR =
    32'(BIAS_BASE_ADDR + OC);

  logic stall;
  logic acc;

  logic signed [15:0] bias [OC];
  logic signed [15:0] coeff;

  logic [GW-1:0] grp;

  logic                 s1_vld;
  logic [GW-1:0]        s1_grp;
  logic signed [PW-1:0] s1_prod [NL];
  logic signed [15:0]   s1_bias [NL];

  logic signed [PW-1:0] prod_c [NL];
  logic signed [15:0]   bias_c [NL];
  logic signed [SW-1:0] sum_c  [NL];

  logic          fin_vld;
  logic [GW-1:0] fin_grp;
  logic [OW-1:0] fin_val [NL];
  logic          fin_last;

  logic [OW*OC-1:0] vbuf;
  logic [OW*OC-1:0] vbuf_nxt;
  logic [OW*OC-1:0] o_data_q;
  logic             o_valid_q;

  assign stall       = o_valid_q && !bus.o_ready;
  assign acc         = bus.i_valid && !stall;
  assign bus.i_ready = !stall;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coeff <= '0;
      for (int c = 0; c < OC; c++)
        bias[c] <= '0;
    end else if (weight_wr_en) begin
      if (weight_wr_addr == COEFF_ADDR)
        coeff <= weight_wr_data;
      for (int c = 0; c < OC; c++)
        if (weight_wr_addr == 32'(BIAS_BASE_ADDR + c))
          bias[c] <= weight_wr_data;
    end
  end

  // Lane l of group k serves channel k*NL+l; out-of-range
  // lanes get a zero bias and are never written to the buffer.
  always_comb begin
    for (int l = 0; l < NL; l++) begin
      prod_c[l] = PW'($signed(bus.i_data[l*MW +: MW]))
                * PW'(coeff);
      bias_c[l] = '0;
    end
    for (int c = 0; c < OC; c++)
      if (grp == GW'(c / NL))
        bias_c[c % NL] = bias[c];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp    <= '0;
      s1_vld <= 1'b0;
      s1_grp <= '0;
      for (int l = 0; l < NL; l++) begin
        s1_prod[l] <= '0;
        s1_bias[l] <= '0;
      end
    end else if (!stall) begin
      s1_vld <= acc;
      if (acc) begin
        s1_grp <= grp;
        for (int l = 0; l < NL; l++) begin
          s1_prod[l] <= prod_c[l];
          s1_bias[l] <= bias_c[l];
        end
        grp <= (grp == GW'(G - 1)) ? '0 : grp + GW'(1);
      end
    end
  end

  always_comb begin
    for (int l = 0; l < NL; l++)
      sum_c[l] = SW'(s1_prod[l])
               + SW'($signed({s1_bias[l], 8'h00}));
  end

  if (DQ) begin : g_dq
    localparam logic [31:0] LS_ADDR = COEFF_ADDR + 32'd1;
    localparam logic signed [SW-1:0] CLO =
      SW'(-64'sd8388608);
    localparam logic signed [SW-1:0] CHI =
      SW'(64'sd8323072);

    logic signed [15:0] lscale;
    logic               s2_vld;
    logic               s3_vld;
    logic [GW-1:0]      s2_grp;
    logic [GW-1:0]      s3_grp;
    logic signed [23:0] clp_c  [NL];
    logic signed [23:0] s2_clp [NL];
    logic signed [39:0] s3_d   [NL];

    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        lscale <= '0;
      else if (weight_wr_en && weight_wr_addr == LS_ADDR)
        lscale <= weight_wr_data;
    end

    // Clamp to [-128, 127] in Q16 so the 24-bit
    // product input always holds the value.
    always_comb begin
      for (int l = 0; l < NL; l++) begin
        if (sum_c[l] < CLO)
          clp_c[l] = CLO[23:0];
        else if (sum_c[l] > CHI)
          clp_c[l] = CHI[23:0];
        else
          clp_c[l] = sum_c[l][23:0];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld <= 1'b0;
        s3_vld <= 1'b0;
        s2_grp <= '0;
        s3_grp <= '0;
        for (int l = 0; l < NL; l++) begin
          s2_clp[l] <= '0;
          s3_d[l]   <= '0;
        end
      end else if (!stall) begin
        s2_vld <= s1_vld;
        s2_grp <= s1_grp;
        s3_vld <= s2_vld;
        s3_grp <= s2_grp;
        for (int l = 0; l < NL; l++) begin
          s2_clp[l] <= clp_c[l];
          s3_d[l]   <= 40'(s2_clp[l]) * 40'(lscale);
        end
      end
    end

    assign fin_vld = s3_vld;
    assign fin_grp = s3_grp;

    always_comb begin
      for (int l = 0; l < NL; l++)
        fin_val[l] = OW'((s3_d[l] + 40'sd8388608) >>> 24);
    end
  end else begin : g_relu
    localparam int RW = SW + 1;

    logic               s2_vld;
    logic [GW-1:0]      s2_grp;
    logic signed [RW-1:0] sh_c [NL];
    logic [7:0]         r_c  [NL];
    logic [7:0]         s2_r [NL];

    always_comb begin
      for (int l = 0; l < NL; l++) begin
        sh_c[l] = (RW'(sum_c[l]) + RW'(32768)) >>> 16;
        if (sh_c[l][RW-1])
          r_c[l] = 8'd0;
        else if (sh_c[l] > RW'(127))
          r_c[l] = 8'd127;
        else
          r_c[l] = sh_c[l][7:0];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld <= 1'b0;
        s2_grp <= '0;
        for (int l = 0; l < NL; l++)
          s2_r[l] <= '0;
      end else if (!stall) begin
        s2_vld <= s1_vld;
        s2_grp <= s1_grp;
        for (int l = 0; l < NL; l++)
          s2_r[l] <= r_c[l];
      end
    end

    assign fin_vld = s2_vld;
    assign fin_grp = s2_grp;

    always_comb begin
      for (int l = 0; l < NL; l++)
        fin_val[l] = s2_r[l];
    end
  end

  always_comb begin
    vbuf_nxt = vbuf;
    for (int c = 0; c < OC; c++)
      if (fin_vld && fin_grp == GW'(c / NL))
        vbuf_nxt[c*OW +: OW] = fin_val[c % NL];
  end

  assign fin_last = fin_vld && (fin_grp == GW'(G - 1));

  // A new final group during a handshake re-arms
  // o_valid in the same cycle, so no bubble appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbuf      <= '0;
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else if (!stall) begin
      if (fin_vld)
        vbuf <= vbuf_nxt;
      if (fin_last) begin
        o_data_q  <= vbuf_nxt;
        o_valid_q <= 1'b1;
      end else if (o_valid_q) begin
        o_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pe_requant_lanes.sv
// tb_pe_requant_lanes: directed bench for relu and dequant instances.
// Both instances: NUM_LANES=2, OUT_CHANNEL=5, shared weight port.
module tb_pe_requant_lanes;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wd;
  logic [31:0] wa;
  logic        we;

  always #5 clk = ~clk;

  pe_requant_lanes_if #(
    .NUM_LANES(2), .OUT_CHANNEL(5), .MACC_WIDTH(21), .OW(8)
  ) a_if ();

  pe_requant_lanes_if #(
    .NUM_LANES(2), .OUT_CHANNEL(5), .MACC_WIDTH(21), .OW(16)
  ) b_if ();

  pe_requant_lanes #(
    .NUM_LANES(2), .OUT_CHANNEL(5), .MACC_WIDTH(21),
    .OUTPUT_MODE("relu"), .BIAS_BASE_ADDR(0)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave),
    .weight_wr_data(wd), .weight_wr_addr(wa),
    .weight_wr_en(we)
  );

  pe_requant_lanes #(
    .NUM_LANES(2), .OUT_CHANNEL(5), .MACC_WIDTH(21),
    .OUTPUT_MODE("dequant"), .BIAS_BASE_ADDR(0)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave),
    .weight_wr_data(wd), .weight_wr_addr(wa),
    .weight_wr_en(we)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [39:0] qa [$];
  int          qta [$];
  logic [79:0] qb [$];

  localparam logic [39:0] V11 = {5{8'd11}};
  localparam logic [39:0] V21 = {5{8'd21}};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && a_if.o_valid && a_if.o_ready) begin
      qa.push_back(a_if.o_data);
      qta.push_back(cyc);
    end
    if (!rst && b_if.o_valid && b_if.o_ready)
      qb.push_back(b_if.o_data);
  end

  task automatic wr(input logic [31:0] a, input logic [15:0] d);
    wa = a;
    wd = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic load_weights;
    for (int i = 0; i < 5; i++)
      wr(32'(i), 16'h0100);
    wr(32'd5, 16'h4000);
    wr(32'd6, 16'h4000);
  endtask

  task automatic send_a(input logic signed [20:0] l0,
                        input logic signed [20:0] l1);
    int n;
    a_if.i_data  = {l1, l0};
    a_if.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_if.i_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (!a_if.i_ready) begin
      fails++;
      $display("FAIL send_a timeout ready=%b want 1",
               a_if.i_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_b(input logic signed [20:0] l0,
                        input logic signed [20:0] l1);
    int n;
    b_if.i_data  = {l1, l0};
    b_if.i_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_if.i_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    tests++;
    if (!b_if.i_ready) begin
      fails++;
      $display("FAIL send_b timeout ready=%b want 1",
               b_if.i_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_qa(input int n);
    int k = 0;
    while (qa.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (qa.size() < n) begin
      fails++;
      $display("FAIL wait_qa got %0d vectors want %0d",
               qa.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_qb(input int n);
    int k = 0;
    while (qb.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (qb.size() < n) begin
      fails++;
      $display("FAIL wait_qb got %0d vectors want %0d",
               qb.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    a_if.i_valid = 1'b0;
    a_if.i_data  = '0;
    a_if.o_ready = 1'b1;
    b_if.i_valid = 1'b0;
    b_if.i_data  = '0;
    b_if.o_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (a_if.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_a_ovalid got %b want 0", a_if.o_valid);
    end
    tests++;
    if (a_if.o_data !== 40'h0) begin
      fails++;
      $display("FAIL rst_a_odata got %h want 0", a_if.o_data);
    end
    tests++;
    if (a_if.i_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_a_iready got %b want 1", a_if.i_ready);
    end
    tests++;
    if (b_if.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_b_ovalid got %b want 0", b_if.o_valid);
    end
    tests++;
    if (b_if.o_data !== 80'h0) begin
      fails++;
      $display("FAIL rst_b_odata got %h want 0", b_if.o_data);
    end
    tests++;
    if (b_if.i_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_b_iready got %b want 1", b_if.i_ready);
    end
  endtask

  task automatic test_weights_reset;
    qa.delete();
    qta.delete();
    repeat (3) send_a(21'sd40, 21'sd40);
    a_if.i_valid = 1'b0;
    wait_qa(1);
    tests++;
    if (qa[0] !== 40'h0) begin
      fails++;
      $display("FAIL zero_weights got %h want 0", qa[0]);
    end
  endtask

  task automatic test_relu_basic;
    qa.delete();
    qta.delete();
    send_a(21'sd40, 21'sd40);
    send_a(21'sd40, 21'sd40);
    send_a(21'sd40, 21'sd1000);
    a_if.i_valid = 1'b0;
    wait_qa(1);
    tests++;
    if (qa[0] !== V11) begin
      fails++;
      $display("FAIL relu_basic got %h want %h", qa[0], V11);
    end
  endtask

  task automatic test_relu_sat;
    logic [39:0] exp_v;
    exp_v = {8'd1, 8'd11, 8'd2, 8'd0, 8'd127};
    qa.delete();
    qta.delete();
    send_a(21'sd1000, -21'sd100);
    send_a(21'sd2, 21'sd40);
    send_a(21'sd0, 21'sd9999);
    a_if.i_valid = 1'b0;
    wait_qa(1);
    tests++;
    if (qa[0] !== exp_v) begin
      fails++;
      $display("FAIL relu_sat got %h want %h", qa[0], exp_v);
    end
  endtask

  task automatic test_dequant;
    logic [79:0] e0;
    logic [79:0] e1;
    logic [79:0] e2;
    e0 = {5{16'd704}};
    e1 = {5{16'd8128}};
    e2 = {16'hFDC0, 16'd64, 16'hE000, 16'd8128, 16'd704};
    qb.delete();
    repeat (3) send_b(21'sd40, 21'sd40);
    b_if.i_valid = 1'b0;
    wait_qb(1);
    tests++;
    if (qb[0] !== e0) begin
      fails++;
      $display("FAIL dq_704 got %h want %h", qb[0], e0);
    end
    repeat (3) send_b(21'sd2000, 21'sd2000);
    b_if.i_valid = 1'b0;
    wait_qb(2);
    tests++;
    if (qb[1] !== e1) begin
      fails++;
      $display("FAIL dq_clamp got %h want %h", qb[1], e1);
    end
    send_b(21'sd40, 21'sd2000);
    send_b(-21'sd2000, 21'sd0);
    send_b(-21'sd40, 21'sd2000);
    b_if.i_valid = 1'b0;
    wait_qb(3);
    tests++;
    if (qb[2] !== e2) begin
      fails++;
      $display("FAIL dq_mixed got %h want %h", qb[2], e2);
    end
  endtask

  task automatic test_back_to_back;
    qa.delete();
    qta.delete();
    a_if.o_ready = 1'b1;
    repeat (3) send_a(21'sd40, 21'sd40);
    repeat (3) send_a(21'sd80, 21'sd80);
    a_if.i_valid = 1'b0;
    wait_qa(2);
    tests++;
    if (qa[0] !== V11) begin
      fails++;
      $display("FAIL b2b_v0 got %h want %h", qa[0], V11);
    end
    tests++;
    if (qa[1] !== V21) begin
      fails++;
      $display("FAIL b2b_v1 got %h want %h", qa[1], V21);
    end
    tests++;
    if (qta[1] - qta[0] !== 3) begin
      fails++;
      $display("FAIL b2b_spacing got %0d want 3",
               qta[1] - qta[0]);
    end
  endtask

  task automatic test_stall;
    qa.delete();
    qta.delete();
    a_if.o_ready = 1'b0;
    fork
      begin
        repeat (3) send_a(21'sd40, 21'sd40);
        repeat (3) send_a(21'sd80, 21'sd80);
        a_if.i_valid = 1'b0;
      end
      begin
        int k = 0;
        @(negedge clk);
        while (!a_if.o_valid && k < 100) begin
          @(negedge clk);
          k++;
        end
        tests++;
        if (!a_if.o_valid) begin
          fails++;
          $display("FAIL stall_first got %b want 1",
                   a_if.o_valid);
        end
        repeat (10) begin
          @(negedge clk);
          tests++;
          if (a_if.o_valid !== 1'b1 || a_if.o_data !== V11) begin
            fails++;
            $display("FAIL stall_hold got %b/%h want 1/%h",
                     a_if.o_valid, a_if.o_data, V11);
          end
          tests++;
          if (a_if.i_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_iready got %b want 0",
                     a_if.i_ready);
          end
        end
        @(posedge clk);
        #1;
        a_if.o_ready = 1'b1;
      end
    join
    wait_qa(2);
    tests++;
    if (qa[0] !== V11) begin
      fails++;
      $display("FAIL stall_v0 got %h want %h", qa[0], V11);
    end
    tests++;
    if (qa[1] !== V21) begin
      fails++;
      $display("FAIL stall_v1 got %h want %h", qa[1], V21);
    end
  endtask

  task automatic test_reset_mid;
    qa.delete();
    qta.delete();
    send_a(21'sd1000, 21'sd1000);
    a_if.i_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (a_if.o_valid !== 1'b0) begin
      fails++;
      $display("FAIL rmid_ovalid got %b want 0", a_if.o_valid);
    end
    tests++;
    if (a_if.i_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_iready got %b want 1", a_if.i_ready);
    end
    @(posedge clk);
    #1;
    load_weights();
    repeat (3) send_a(21'sd40, 21'sd40);
    a_if.i_valid = 1'b0;
    wait_qa(1);
    tests++;
    if (qa[0] !== V11) begin
      fails++;
      $display("FAIL rmid_vec got %h want %h", qa[0], V11);
    end
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (qa.size() !== 1) begin
      fails++;
      $display("FAIL rmid_count got %0d want 1", qa.size());
    end
  endtask

  initial begin
    test_reset();
    test_weights_reset();
    load_weights();
    test_relu_basic();
    test_relu_sat();
    test_dequant();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
